fir_ntap_stream: RTL and testbench

Parametrised N-tap streaming FIR filter. It is the successor to the fixed 4-tap unit-coefficient moving-sum filter. It adds:
- a configurable tap count;
- signed per-tap coefficients;
- valid/ready flow control with back-pressure;
- a window-priming state machine;
- a registered carry-select adder tree.

It sits in the datapath between a sample source and a downstream consumer that can stall.

---
 rtl/fir_ntap_pkg.sv | 21 ++
 rtl/fir_ntap_stream_csa_add.sv | 50 +++++
 rtl/fir_ntap_stream.sv | 138 +++++++++++++
 tb/tb_fir_ntap_stream.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_ntap_pkg.sv
// Shared types and constants for the N-tap streaming FIR.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package fir_ntap_pkg;

    typedef enum logic {
        PRIME = 1'b0,
        RUN   = 1'b1
    } fir_state_e;

    localparam int FIR_DEF_W       = 16;
    localparam int FIR_DEF_CW      = 8;
    localparam int FIR_DEF_TAPS    = 8;
    localparam int FIR_DEF_CSA_BLK = 4;

    // Width of a sum-tree level: level 0 is the product width, each level adds a bit.
    function automatic int fir_lvl_w(input int w, input int cw, input int level);
        return w + cw + level;
    endfunction

endpackage

// File: rtl/fir_ntap_stream_csa_add.sv
// Signed carry-select adder, WIDTH-bit operands to a WIDTH+1-bit sum.
// Latency: combinational.
// Backpressure: none (pure logic).
module csa_add
    import fir_ntap_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int BLK   = 4
) (
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic signed [WIDTH:0]   sum
);

    localparam int SW = WIDTH + 1;
    localparam int NB = (SW + BLK - 1) / BLK;

    logic [SW-1:0] ea;
    logic [SW-1:0] eb;
    wire  [SW-1:0] s_dat;
    wire  [NB-1:0] cy;

    // Sign-extend first so the extra result bit is just another block bit.
    assign ea    = {a[WIDTH-1], a};
    assign eb    = {b[WIDTH-1], b};
    assign cy[0] = 1'b0;

    // Each block precomputes both carry-in outcomes; the incoming carry only selects.
    for (genvar gb = 0; gb < NB; gb++) begin : g_blk
        localparam int LO = gb * BLK;
        localparam int BW = (gb == NB - 1) ? (SW - LO) : BLK;
        if (gb == NB - 1) begin : g_top
            logic [BW-1:0] s0;
            logic [BW-1:0] s1;
            assign s0 = ea[LO +: BW] + eb[LO +: BW];
            assign s1 = ea[LO +: BW] + eb[LO +: BW] + BW'(1);
            assign s_dat[LO +: BW] = cy[gb] ? s1 : s0;
        end else begin : g_mid
            logic [BW:0] s0;
            logic [BW:0] s1;
            assign s0 = {1'b0, ea[LO +: BW]} + {1'b0, eb[LO +: BW]};
            assign s1 = {1'b0, ea[LO +: BW]} + {1'b0, eb[LO +: BW]} + (BW + 1)'(1);
            assign s_dat[LO +: BW] = cy[gb] ? s1[BW-1:0] : s0[BW-1:0];
            assign cy[gb + 1]      = cy[gb] ? s1[BW] : s0[BW];
        end
    end

    assign sum = s_dat;

endmodule

// File: rtl/fir_ntap_stream.sv
// Streaming N-tap FIR (signed coefs when FIR_COEF_LOAD_EN is defined, else unit-coef moving sum).
// Latency: accept at edge k -> out_valid after edge k+1+log2(TAPS); one sample per cycle.
// Backpressure: a held output (out_valid && !out_ready) freezes every stage and drops in_ready.
module fir_ntap_stream
    import fir_ntap_pkg::*;
#(
    parameter int W       = FIR_DEF_W,
    parameter int CW      = FIR_DEF_CW,
    parameter int TAPS    = FIR_DEF_TAPS,
    parameter int CSA_BLK = FIR_DEF_CSA_BLK
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic                                 clear,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic signed [W-1:0]                  in_data,
    input  logic                                 coef_wr,
    input  logic [$clog2(TAPS)-1:0]              coef_addr,
    input  logic signed [CW-1:0]                 coef_data,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic signed [W+CW+$clog2(TAPS)-1:0]  out_data
);

    localparam int L  = $clog2(TAPS);
    localparam int PW = W + CW;
    localparam int OW = fir_lvl_w(W, CW, L);

    fir_state_e          state;
    logic [L-1:0]        cnt;
    logic                x_vld;
    logic [L:0]          pipe_vld;
    logic signed [W-1:0] x_dat [TAPS];

    // Heap-ordered tree: node j sums nodes 2j and 2j+1; products sit at TAPS..2*TAPS-1, root at 1.
    logic signed [OW-1:0] node_dat [1:2*TAPS-1];
    wire  signed [OW-1:0] sum_dat  [1:TAPS-1];

    logic en;
    logic acc;

    assign en        = !(out_valid && !out_ready);
    assign in_ready  = reset_n && en && !clear;
    assign acc       = in_valid && in_ready;
    assign out_valid = pipe_vld[L];
    assign out_data  = node_dat[1];

`ifdef FIR_COEF_LOAD_EN
    logic signed [CW-1:0] coef [TAPS];

    // Coefficient file: writes land regardless of stalls or flushes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < TAPS; i++) coef[i] <= CW'(1);
        end else if (coef_wr) begin
            coef[coef_addr] <= coef_data;
        end
    end
`else
    logic unused_coef;
    assign unused_coef = ^{coef_wr, coef_addr, coef_data};
`endif

    // Window priming: results are tagged valid only once TAPS samples fill the delay line.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= PRIME;
            cnt   <= '0;
            x_vld <= 1'b0;
        end else if (clear) begin
            state <= PRIME;
            cnt   <= '0;
            x_vld <= 1'b0;
        end else if (en) begin
            x_vld <= acc && ((state == RUN) || (cnt == L'(TAPS - 1)));
            if (acc && (state == PRIME)) begin
                cnt <= cnt + 1'b1;
                if (cnt == L'(TAPS - 1)) state <= RUN;
            end
        end
    end

    // Delay line shifts only on an accepted sample; a flush empties it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < TAPS; i++) x_dat[i] <= '0;
        end else if (clear) begin
            for (int i = 0; i < TAPS; i++) x_dat[i] <= '0;
        end else if (acc) begin
            x_dat[0] <= in_data;
            for (int i = 1; i < TAPS; i++) x_dat[i] <= x_dat[i-1];
        end
    end

    // Valid bits ride alongside the product and tree stages; a flush drops in-flight results.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pipe_vld <= '0;
        end else if (clear) begin
            pipe_vld <= '0;
        end else if (en) begin
            pipe_vld <= {pipe_vld[L-1:0], x_vld};
        end
    end

    for (genvar j = 1; j < TAPS; j++) begin : g_node
        localparam int LV = L + 1 - $clog2(j + 1);
        localparam int IW = fir_lvl_w(W, CW, LV - 1);
        logic signed [IW:0] s;
        csa_add #(
            .WIDTH (IW),
            .BLK   (CSA_BLK)
        ) u_add (
            .a   (node_dat[2*j][IW-1:0]),
            .b   (node_dat[2*j+1][IW-1:0]),
            .sum (s)
        );
        assign sum_dat[j] = OW'(s);
    end

    // Product stage and every tree level register together, all gated by the stall enable.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int n = 1; n < 2 * TAPS; n++) node_dat[n] <= '0;
        end else if (en) begin
            for (int i = 0; i < TAPS; i++) begin
`ifdef FIR_COEF_LOAD_EN
                node_dat[TAPS + i] <= OW'(PW'(x_dat[i]) * PW'(coef[i]));
`else
                node_dat[TAPS + i] <= OW'(PW'(x_dat[i]));
`endif
            end
            for (int j = 1; j < TAPS; j++) node_dat[j] <= sum_dat[j];
        end
    end

endmodule

// File: tb/tb_fir_ntap_stream.sv
// Self-checking bench for fir_ntap_stream against a sliding-window reference model.
// Latency: checks the prime-to-first-result latency explicitly.
// Backpressure: checks in_ready and output hold during consumer stalls.
module tb_fir_ntap_stream;

    localparam int W    = 16;
    localparam int CW   = 8;
    localparam int TAPS = 8;
    localparam int L    = $clog2(TAPS);
    localparam int OW   = W + CW + L;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic                 clear;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [W-1:0]  in_data;
    logic                 coef_wr;
    logic [L-1:0]         coef_addr;
    logic signed [CW-1:0] coef_data;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [OW-1:0] out_data;

    always #5 clk = ~clk;

    fir_ntap_stream #(
        .W       (W),
        .CW      (CW),
        .TAPS    (TAPS),
        .CSA_BLK (4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .coef_wr   (coef_wr),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    int     vectors     = 0;
    int     miscompares = 0;
    int     mc [TAPS];
    int     win [$];
    longint exp_q [$];
    longint obs_q [$];
    int     vld_steps [$];
    int     stepn    = 0;
    int     last_acc = 0;
    bit     prev_stall = 1'b0;
    logic signed [OW-1:0] prev_dat;
    int     imp_c   [TAPS] = '{3, -2, 5, 0, 7, -1, 4, -128};
    int     imp_exp [TAPS];
    longint ext_exp;

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Filter output for the current window: newest sample pairs with coefficient 0.
    function automatic longint model_sum();
        longint s = 0;
        for (int i = 0; i < TAPS; i++) s += longint'(win[i]) * longint'(mc[i]);
        return s;
    endfunction

    task automatic model_reset();
        win.delete();
        exp_q.delete();
        prev_stall = 1'b0;
        for (int i = 0; i < TAPS; i++) mc[i] = 1;
    endtask

    // One clock: sample and score at the falling edge, let the rising edge act, return 1 time unit later.
    task automatic step();
        bit acc;
        bit take;
        @(negedge clk);
        acc  = in_valid && in_ready;
        take = out_valid && out_ready;
        if (prev_stall) begin
            check("stall_hold_vld", out_valid, 1);
            check("stall_hold_dat", out_data, prev_dat);
        end
        if (out_valid && !out_ready) check("stall_in_rdy", in_ready, 0);
        if (out_valid) vld_steps.push_back(stepn);
        if (take) begin
            obs_q.push_back(out_data);
            check("out_pending", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) check("out_dat", out_data, exp_q.pop_front());
        end
        prev_stall = out_valid && !out_ready && !clear;
        prev_dat   = out_data;
        if (clear) begin
            win.delete();
            exp_q.delete();
        end
        if (acc) begin
            win.push_front(int'(in_data));
            if (win.size() > TAPS) void'(win.pop_back());
            if (win.size() == TAPS) exp_q.push_back(model_sum());
            last_acc = stepn;
        end
        @(posedge clk);
        #1;
        stepn++;
    endtask

    task automatic wr_coef(input int a, input int d);
        coef_wr   = 1'b1;
        coef_addr = L'(a);
        coef_data = CW'(d);
        step();
        coef_wr = 1'b0;
`ifdef FIR_COEF_LOAD_EN
        mc[a] = d;
`endif
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic drain(input string tag);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (L + 4) step();
        check(tag, exp_q.size(), 0);
    endtask

    initial begin
        reset_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0;
        out_ready = 1'b1; coef_wr = 1'b0; coef_addr = '0; coef_data = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_vld", out_valid, 0);
        check("rst_out_dat", out_data, 0);
        check("rst_in_rdy", in_ready, 0);
        reset_n = 1'b1;
        step();
        check("idle_in_rdy", in_ready, 1);

        // Prime with 1..8 under reset coefficients.
        vld_steps.delete();
        obs_q.delete();
        in_valid = 1'b1;
        for (int i = 1; i <= TAPS; i++) begin
            in_data = W'(i);
            step();
        end
        drain("prime_drain");
        check("prime_pulses", vld_steps.size(), 1);
        if (vld_steps.size() > 0) check("prime_latency", vld_steps[0], last_acc + 2 + L);
        if (obs_q.size() > 0) check("prime_sum", obs_q[0], 36);

        // Impulse response.
`ifdef FIR_COEF_LOAD_EN
        for (int i = 0; i < TAPS; i++) imp_exp[i] = imp_c[i];
`else
        for (int i = 0; i < TAPS; i++) imp_exp[i] = 1;
`endif
        for (int i = 0; i < TAPS; i++) wr_coef(i, imp_c[i]);
        pulse_clear();
        obs_q.delete();
        in_valid = 1'b1;
        for (int i = 0; i < 2 * TAPS; i++) begin
            in_data = (i == TAPS) ? W'(1) : W'(0);
            step();
        end
        drain("imp_drain");
        check("imp_count", obs_q.size(), TAPS + 1);
        if (obs_q.size() == TAPS + 1)
            for (int i = 0; i < TAPS; i++) check("imp_tap", obs_q[i+1], imp_exp[i]);

        // Extremes: most negative sample and coefficient.
`ifdef FIR_COEF_LOAD_EN
        ext_exp = 33554432;
`else
        ext_exp = -262144;
`endif
        for (int i = 0; i < TAPS; i++) wr_coef(i, -128);
        pulse_clear();
        obs_q.delete();
        in_valid = 1'b1;
        in_data  = W'(-32768);
        repeat (TAPS) step();
        drain("ext_drain");
        if (obs_q.size() > 0) check("ext_sum", obs_q[obs_q.size()-1], ext_exp);

        // Back-pressure: 5-cycle consumer stall in the middle of a ramp.
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_data   = W'(i * 37 - 300);
            out_ready = !(i >= 10 && i < 15);
            step();
        end
        drain("bp_drain");

        // Flush in RUN: needs a full window again before the next result.
        in_valid = 1'b1;
        for (int i = 0; i < L + 3; i++) begin
            in_data = W'(i + 5);
            step();
        end
        check("clr_pre_vld", out_valid, 1);
        pulse_clear();
        check("clr_post_vld", out_valid, 0);
        vld_steps.delete();
        for (int i = 0; i < TAPS - 1; i++) begin
            in_data = W'(2 * i + 1);
            step();
        end
        in_valid = 1'b0;
        repeat (L + 3) step();
        check("clr_7_vld", vld_steps.size(), 0);
        in_valid = 1'b1;
        in_data  = W'(9);
        step();
        drain("clr_drain");
        check("clr_8_vld", vld_steps.size(), 1);

        // Asynchronous reset while stalled.
        in_valid  = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < L + 4; i++) begin
            in_data = W'(100 + i);
            step();
        end
        check("arst_pre_vld", out_valid, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_out_vld", out_valid, 0);
        check("arst_out_dat", out_data, 0);
        check("arst_in_rdy", in_ready, 0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        obs_q.delete();
        in_valid = 1'b1;
        in_data  = W'(1);
        repeat (TAPS) step();
        drain("arst_drain");
        check("arst_count", obs_q.size(), 1);
        if (obs_q.size() > 0) check("arst_sum", obs_q[0], 8);

        // Randomized traffic with random coefficients.
        in_valid = 1'b0;
        for (int i = 0; i < TAPS; i++) wr_coef(i, int'($urandom_range(255, 0)) - 128);
        for (int n = 0; n < 1500; n++) begin
            in_valid  = ($urandom_range(3, 0) != 0);
            in_data   = W'($urandom);
            out_ready = ($urandom_range(3, 0) != 0);
            clear     = ($urandom_range(63, 0) == 0);
            step();
        end
        clear = 1'b0;
        drain("rand_drain");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
